// File: rtl/pu_msp430_pkg.sv
// Shared widths, FSM state encoding and request payload for the peripheral arbiter.
package pu_msp430_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WE_W   = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [WE_W-1:0]   we;
    logic              lock;
  } per_req_t;

endpackage

// File: rtl/pu_msp430_rr_arb2.sv
// Two-requester round-robin picker; mask restricts eligibility while a lock is held.
module pu_msp430_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       take,
  output logic [1:0] gnt_c
);

  logic       last_grant;
  logic [1:0] elig;

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    elig  = req & mask;
    gnt_c = 2'b00;
    case (elig)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = last_grant ? 2'b01 : 2'b10;
      default: gnt_c = 2'b00;
    endcase
  end

  // Reset to master 1 so master 0 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (take && (gnt_c != 2'b00)) begin
      last_grant <= gnt_c[1];
    end
  end

endmodule

// File: rtl/pu_msp430_per_arbiter.sv
// Two-master peripheral bus arbiter: IDLE/ACCESS/RESP transaction FSM with
// round-robin arbitration and a lock for read-modify-write sequences.
module pu_msp430_per_arbiter
  import pu_msp430_pkg::*;
#(
  parameter int unsigned LOCK_TMO = 16
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        m0_req,
  input  logic [13:0] m0_addr,
  input  logic [15:0] m0_din,
  input  logic [1:0]  m0_we,
  input  logic        m0_lock,
  output logic        m0_ack,
  output logic [15:0] m0_dout,
  input  logic        m1_req,
  input  logic [13:0] m1_addr,
  input  logic [15:0] m1_din,
  input  logic [1:0]  m1_we,
  input  logic        m1_lock,
  output logic        m1_ack,
  output logic [15:0] m1_dout,
  output logic        per_en,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic [1:0]  per_we,
  input  logic [15:0] per_dout,
  output logic [1:0]  grant,
  output logic        lock_err
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TMO - 1);

  state_t           state;
  logic             lock_active;
  logic             lock_owner;
  logic             cur_lock;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       mask_c;
  logic [1:0]       win_c;
  logic             owner_req_c;
  per_req_t         sel_c;

  always_comb begin
    mask_c      = 2'b11;
    owner_req_c = lock_owner ? m1_req : m0_req;
    if (lock_active) begin
      mask_c = lock_owner ? 2'b10 : 2'b01;
    end
    sel_c = win_c[1] ? {m1_addr, m1_din, m1_we, m1_lock}
                     : {m0_addr, m0_din, m0_we, m0_lock};
  end

  pu_msp430_rr_arb2 u_rr (
    .clk   (mclk),
    .rst_n (puc_rst_n),
    .req   ({m1_req, m0_req}),
    .mask  (mask_c),
    .take  (state == ST_IDLE),
    .gnt_c (win_c)
  );

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state       <= ST_IDLE;
      per_en      <= 1'b0;
      per_addr    <= '0;
      per_din     <= '0;
      per_we      <= '0;
      grant       <= 2'b00;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_dout     <= '0;
      m1_dout     <= '0;
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
      cur_lock    <= 1'b0;
      lock_cnt    <= '0;
      lock_err    <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Idle cycles without the owner asking age the lock toward expiry.
          if (lock_active && !owner_req_c) begin
            if (lock_cnt == TMO_LAST) begin
              lock_active <= 1'b0;
              lock_err    <= 1'b1;
              lock_cnt    <= '0;
            end else begin
              lock_cnt <= lock_cnt + CNT_W'(1);
            end
          end
          if (win_c != 2'b00) begin
            grant    <= win_c;
            per_addr <= sel_c.addr;
            per_din  <= sel_c.din;
            per_we   <= sel_c.we;
            cur_lock <= sel_c.lock;
            lock_cnt <= '0;
            per_en   <= 1'b1;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          per_en      <= 1'b0;
          m0_ack      <= grant[0];
          m1_ack      <= grant[1];
          m0_dout     <= (grant[0] && (per_we == 2'b00)) ? per_dout : '0;
          m1_dout     <= (grant[1] && (per_we == 2'b00)) ? per_dout : '0;
          lock_active <= cur_lock;
          lock_owner  <= grant[1];
          state       <= ST_RESP;
        end
        ST_RESP: begin
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
          m0_dout <= '0;
          m1_dout <= '0;
          grant   <= 2'b00;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_msp430_per_arbiter.sv
// Directed, table-driven bench for the peripheral arbiter (LOCK_TMO = 4).
module tb_pu_msp430_per_arbiter;

  logic        mclk;
  logic        puc_rst_n;
  logic        m0_req, m1_req, m0_lock, m1_lock;
  logic [13:0] m0_addr, m1_addr;
  logic [15:0] m0_din, m1_din;
  logic [1:0]  m0_we, m1_we;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_dout, m1_dout;
  logic        per_en;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic [1:0]  grant;
  logic        lock_err;

  int checks = 0;
  int errors = 0;
  int cur_row = 0;

  pu_msp430_per_arbiter #(.LOCK_TMO(4)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din), .m0_we(m0_we),
    .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din), .m1_we(m1_we),
    .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_dout(m1_dout),
    .per_en(per_en), .per_addr(per_addr), .per_din(per_din), .per_we(per_we),
    .per_dout(per_dout), .grant(grant), .lock_err(lock_err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [13:0] a;
    logic [15:0] d;
    logic [1:0]  w;
    logic        l;
  } pl_t;

  typedef struct {
    logic        rst;
    logic        r0;
    logic [2:0]  p0;
    logic        r1;
    logic [2:0]  p1;
    logic [15:0] pd;
    logic        en;
    logic [1:0]  gnt;
    logic        k0;
    logic        k1;
    logic [15:0] o0;
    logic [15:0] o1;
    logic        le;
    logic [13:0] pa;
    logic [15:0] pdi;
    logic [1:0]  pw;
  } vec_t;

  pl_t  pl [8];
  vec_t vecs[$];

  function automatic vec_t row(input bit rst, input bit r0, input int p0, input bit r1,
                               input int p1, input int pd, input bit en, input int gnt,
                               input bit k0, input bit k1, input int o0, input int o1,
                               input bit le, input int pa, input int pdi, input int pw);
    vec_t v;
    v.rst = rst;  v.r0 = r0;  v.p0 = 3'(p0);  v.r1 = r1;  v.p1 = 3'(p1);
    v.pd  = 16'(pd);  v.en = en;  v.gnt = 2'(gnt);  v.k0 = k0;  v.k1 = k1;
    v.o0  = 16'(o0);  v.o1 = 16'(o1);  v.le = le;
    v.pa  = 14'(pa);  v.pdi = 16'(pdi);  v.pw = 2'(pw);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d, t=%0t): got %h expected %h", nm, cur_row, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input int p0, input logic r1, input int p1,
                       input logic [15:0] pd);
    m0_req = r0; m0_addr = pl[p0].a; m0_din = pl[p0].d; m0_we = pl[p0].w; m0_lock = pl[p0].l;
    m1_req = r1; m1_addr = pl[p1].a; m1_din = pl[p1].d; m1_we = pl[p1].w; m1_lock = pl[p1].l;
    per_dout = pd;
  endtask

  // Leaves the bench just after a clock edge with reset released.
  task automatic do_reset();
    puc_rst_n = 1'b0;
    drive(1'b0, 7, 1'b0, 7, 16'h0000);
    repeat (2) @(posedge mclk);
    #1;
    chk("rst_per_en", 32'(per_en), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
    chk("rst_douts", {m0_dout, m1_dout}, 32'd0);
    chk("rst_lock_err", 32'(lock_err), 32'd0);
    chk("rst_per_addr", 32'(per_addr), 32'd0);
    chk("rst_per_din", 32'(per_din), 32'd0);
    chk("rst_per_we", 32'(per_we), 32'd0);
    puc_rst_n = 1'b1;
  endtask

  initial begin
    pl[0] = '{14'h0048, 16'h0000, 2'b00, 1'b0};
    pl[1] = '{14'h0100, 16'h3C00, 2'b10, 1'b0};
    pl[2] = '{14'h0030, 16'h0000, 2'b00, 1'b1};
    pl[3] = '{14'h0030, 16'hBEEF, 2'b11, 1'b0};
    pl[4] = '{14'h0040, 16'h00FF, 2'b01, 1'b0};
    pl[5] = '{14'h0050, 16'h0000, 2'b00, 1'b1};
    pl[6] = '{14'h0060, 16'h0000, 2'b00, 1'b0};
    pl[7] = '{14'h0000, 16'h0000, 2'b00, 1'b0};

    // Single read by m0, then byte write by m1 (per_dout garbage must not leak).
    vecs.push_back(row(1, 1,0, 0,1, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 1,0, 0,1, 'h00A5,  1,1, 0,0, 0,0, 0, 'h0048,0,0));
    vecs.push_back(row(0, 1,0, 0,1, 0,       0,1, 1,0, 'h00A5,0, 0, 0,0,0));
    vecs.push_back(row(0, 0,0, 1,1, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 0,0, 1,1, 'hFFFF,  1,2, 0,0, 0,0, 0, 'h0100,'h3C00,2));
    vecs.push_back(row(0, 0,0, 1,1, 0,       0,2, 0,1, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 0,0, 0,1, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    // Locked read-modify-write by m0 while m1 keeps requesting.
    vecs.push_back(row(1, 1,2, 1,4, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 1,2, 1,4, 'h5A5A,  1,1, 0,0, 0,0, 0, 'h0030,0,0));
    vecs.push_back(row(0, 1,2, 1,4, 0,       0,1, 1,0, 'h5A5A,0, 0, 0,0,0));
    vecs.push_back(row(0, 1,3, 1,4, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 1,3, 1,4, 0,       1,1, 0,0, 0,0, 0, 'h0030,'hBEEF,3));
    vecs.push_back(row(0, 1,3, 1,4, 0,       0,1, 1,0, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 0,3, 1,4, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 0,3, 1,4, 'h1111,  1,2, 0,0, 0,0, 0, 'h0040,'h00FF,1));
    vecs.push_back(row(0, 0,3, 1,4, 0,       0,2, 0,1, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 0,3, 0,4, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    // Lock timeout: m0 locks then goes quiet; m1 waits four idle cycles.
    vecs.push_back(row(1, 1,5, 0,6, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 1,5, 0,6, 'h0001,  1,1, 0,0, 0,0, 0, 'h0050,0,0));
    vecs.push_back(row(0, 1,5, 0,6, 0,       0,1, 1,0, 'h0001,0, 0, 0,0,0));
    vecs.push_back(row(0, 0,5, 1,6, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 0,5, 1,6, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 0,5, 1,6, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 0,5, 1,6, 0,       0,0, 0,0, 0,0, 0, 0,0,0));
    vecs.push_back(row(0, 0,5, 1,6, 0,       0,0, 0,0, 0,0, 1, 0,0,0));
    vecs.push_back(row(0, 0,5, 1,6, 'h7777,  1,2, 0,0, 0,0, 0, 'h0060,0,0));
    vecs.push_back(row(0, 0,5, 1,6, 0,       0,2, 0,1, 0,'h7777, 0, 0,0,0));
    vecs.push_back(row(0, 0,5, 0,6, 0,       0,0, 0,0, 0,0, 0, 0,0,0));

    puc_rst_n = 1'b0;
    drive(1'b0, 7, 1'b0, 7, 16'h0000);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      cur_row = i;
      if (v.rst) do_reset();
      chk("per_en", 32'(per_en), 32'(v.en));
      chk("grant", 32'(grant), 32'(v.gnt));
      chk("m0_ack", 32'(m0_ack), 32'(v.k0));
      chk("m1_ack", 32'(m1_ack), 32'(v.k1));
      chk("m0_dout", 32'(m0_dout), 32'(v.o0));
      chk("m1_dout", 32'(m1_dout), 32'(v.o1));
      chk("lock_err", 32'(lock_err), 32'(v.le));
      if (v.en) begin
        chk("per_addr", 32'(per_addr), 32'(v.pa));
        chk("per_din", 32'(per_din), 32'(v.pdi));
        chk("per_we", 32'(per_we), 32'(v.pw));
      end
      drive(v.r0, int'(v.p0), v.r1, int'(v.p1), v.pd);
      @(posedge mclk);
      #1;
    end

    // Contention: both masters read continuously; grants alternate, m0 first.
    cur_row = 1000;
    do_reset();
    drive(1'b1, 0, 1'b1, 6, 16'h1234);
    for (int c = 0; c < 18; c++) begin
      logic [1:0] eg;
      eg = (c % 3 == 0) ? 2'b00 : ((c % 6 < 3) ? 2'b01 : 2'b10);
      cur_row = 1000 + c;
      chk("rr_grant", 32'(grant), 32'(eg));
      chk("rr_m0_ack", 32'(m0_ack), 32'(c % 6 == 2));
      chk("rr_m1_ack", 32'(m1_ack), 32'(c % 6 == 5));
      chk("rr_m0_dout", 32'(m0_dout), (c % 6 == 2) ? 32'h1234 : 32'h0);
      chk("rr_m1_dout", 32'(m1_dout), (c % 6 == 5) ? 32'h1234 : 32'h0);
      @(posedge mclk);
      #1;
    end

    // Reset asserted during ACCESS aborts the transfer; m0 wins afterwards.
    cur_row = 2000;
    do_reset();
    drive(1'b1, 0, 1'b0, 6, 16'h0000);
    @(posedge mclk);
    #1;
    chk("ra_per_en_pre", 32'(per_en), 32'd1);
    chk("ra_grant_pre", 32'(grant), 32'd1);
    #3;
    puc_rst_n = 1'b0;
    #1;
    chk("ra_per_en", 32'(per_en), 32'd0);
    chk("ra_grant", 32'(grant), 32'd0);
    chk("ra_per_addr", 32'(per_addr), 32'd0);
    chk("ra_acks", 32'({m0_ack, m1_ack}), 32'd0);
    drive(1'b1, 0, 1'b1, 6, 16'h0000);
    repeat (2) begin
      @(posedge mclk);
      #1;
      chk("ra_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
    end
    puc_rst_n = 1'b1;
    @(posedge mclk);
    #1;
    chk("ra_first_grant", 32'(grant), 32'd1);
    drive(1'b0, 7, 1'b0, 7, 16'h0000);
    repeat (3) @(posedge mclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_msp430_per_arbiter.md
PU_MSP430_PER_ARBITER -- requirements
Module: pu_msp430_per_arbiter

Interface
REQ-001 Parameter: LOCK_TMO, 16, number of IDLE cycles a held lock survives without an owner request (range 2..255).
REQ-002 Clocking: single clock; reset asynchronous, active-low.
REQ-003 mclk  in  1  main system clock.
REQ-004 puc_rst_n  in  1  main system reset, asynchronous, active-low.
REQ-005 m0_req / m1_req  in  1  access request from master 0 (CPU) / master 1 (DMA/debug); held stable until ack.
REQ-006 m0_addr / m1_addr  in  14  peripheral word address.
REQ-007 m0_din / m1_din  in  16  write data.
REQ-008 m0_we / m1_we  in  2  byte write enables; 2'b00 means read.
REQ-009 m0_lock / m1_lock  in  1  keep ownership after this access (read-modify-write).
REQ-010 m0_ack / m1_ack  out  1  one-cycle completion pulse.
REQ-011 m0_dout / m1_dout  out  16  read data, valid only while ack is high, otherwise 0.
REQ-012 per_en  out  1  peripheral enable.
REQ-013 per_addr  out  14  registered peripheral address.
REQ-014 per_din  out  16  registered peripheral write data.
REQ-015 per_we  out  2  registered write enables.
REQ-016 per_dout  in  16  OR-combined peripheral read data, valid in the per_en cycle.
REQ-017 grant  out  2  one-hot current owner; 0 in IDLE.
REQ-018 lock_err  out  1  one-cycle pulse when a lock expires by timeout.

Function
REQ-019 FSM states: IDLE, ACCESS, RESP.
REQ-020 IDLE, no eligible request: stay in IDLE; per_en=0; grant=0.
REQ-021 IDLE, eligible request: register the winner's addr/din/we/lock, set grant, go to ACCESS (cycle N).
REQ-022 ACCESS (N+1): per_en=1 with the registered fields; capture per_dout into the read register only when registered we==0; go to RESP.
REQ-023 RESP (N+2): winner ack=1; dout=captured data for reads, 0 for writes; go to IDLE.
REQ-024 Requests are not sampled in ACCESS or RESP; a req still high in N+3 is a new transaction. Throughput is one access per 3 cycles.
REQ-025 Round-robin: the last_grant register records the most recently granted master; on simultaneous eligible requests, the master that is not last_grant wins.
REQ-026 A single requester wins regardless of last_grant.
REQ-027 Lock set: a granted access with lock=1 sets lock_active and records lock_owner, effective at RESP.
REQ-028 Lock held: while lock_active, only lock_owner is eligible; the other req waits.
REQ-029 Lock release: a granted owner access with lock=0 clears lock_active at its RESP.
REQ-030 Lock counter: increments in each IDLE cycle with lock_active and owner req=0; resets to 0 on any owner grant.
REQ-031 Lock timeout: counter reaching LOCK_TMO-1 clears lock_active, pulses lock_err for one cycle and resets the counter; arbitration in that cycle still obeys the lock, and the other master becomes eligible next cycle.
REQ-032 Timeout does not change last_grant.
REQ-033 ack is never asserted to both masters; grant is always zero or one-hot.

Reset
REQ-034 On puc_rst_n low (asynchronous): state=IDLE, per_en=0, per_addr=0, per_din=0, per_we=0, grant=0, acks=0, douts=0, read register=0, lock_active=0, lock counter=0, lock_err=0, last_grant=master 1 (master 0 wins first contest).
REQ-035 Reset asserted mid-transaction aborts it with no ack; the requester reissues after reset.

Structure
REQ-036 Shared package pu_msp430_pkg holds the FSM state enum and the 14-bit address and 16-bit data width constants.
REQ-037 One sub-module, pu_msp430_rr_arb2: two-request round-robin picker with a lock mask, combinational grant plus last_grant register.

Verification
REQ-038 Single read: m0 read addr 14'h0048, per_dout=16'h00A5 in the per_en cycle -> per_en high exactly at N+1, m0_ack at N+2 with m0_dout=16'h00A5.
REQ-039 Byte write: m1 we=2'b10, din=16'h3C00 -> per_we=2'b10 and per_din=16'h3C00 while per_en=1; m1_ack with m1_dout=0.
REQ-040 Contention: both masters request continuously for 6 accesses -> grants alternate m0, m1, m0, ..., m0 first after reset.
REQ-041 Lock: m0 lock=1 read, then lock=0 write, with m1 requesting throughout -> m1 not granted until after m0's second ack.
REQ-042 Timeout: m0 locks, drops req, m1 requesting, LOCK_TMO=4 -> lock_err pulses after 4 IDLE cycles; m1 granted the following cycle.
REQ-043 Reset during ACCESS -> all outputs 0 immediately; no ack; next contest won by m0.
